// File: rtl/unidade_funcional_r_pipe.sv
// Pipelined R-type functional unit. Accepts one tagged op per clock and runs it
// through a fixed-latency pipeline. Results queue in a small FIFO that drains
// onto the CDB under an arbiter grant.
// Handshake:
//   - Issue is accepted on a rising edge when Ready_to_uf=1 and Busy=0.
//   - A CDB transfer happens on a rising edge when Write_Enable_CDB=1 and
//     CDB_grant=1.
//   - Busy is derived from registered state only.
//   - Busy is credit-based (credits = ops in flight + buffered), so the FIFO
//     can never overflow.
module unidade_funcional_r_pipe #(
  parameter int WIDTH     = 16,
  parameter int TAG_W     = 3,
  parameter int LATENCY   = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Ufop,
  input  logic [TAG_W-1:0] Tag_in,
  input  logic             Ready_to_uf,
  output logic             Busy,
  output logic [WIDTH-1:0] Q,
  output logic [TAG_W-1:0] Q_tag,
  output logic             Write_Enable_CDB,
  input  logic             CDB_grant
);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  logic             issue;
  logic [WIDTH-1:0] alu_res;
  logic             exit_v;
  logic             exit_nop;
  logic [WIDTH-1:0] exit_res;
  logic [TAG_W-1:0] exit_tag;
  logic             buf_wr;
  logic             nop_exit;
  logic             pop;

  assign issue = Ready_to_uf && !Busy;

  // Result of the op being issued; it then travels down the pipe with its tag
  always_comb begin
    alu_res = '0;
    case (Ufop)
      3'b001: alu_res = A + B;
      3'b010: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      3'b011: alu_res = {{(WIDTH-1){1'b0}}, (A == B)};
      3'b100: alu_res = B + FOUR;
      3'b101: alu_res = B - FOUR;
      3'b110: alu_res = A - B;
      3'b111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_res = '0;
    endcase
  end

  generate
    if (LATENCY == 1) begin : g_direct
      // Single-cycle unit: the FIFO itself is the only register on the path
      always_comb begin
        exit_v   = issue;
        exit_nop = (Ufop == 3'b000);
        exit_res = alu_res;
        exit_tag = Tag_in;
      end
    end else begin : g_pipe
      localparam int NS = LATENCY - 1;
      logic [NS-1:0]            pv_q, pv_d;
      logic [NS-1:0]            pn_q, pn_d;
      logic [NS-1:0][WIDTH-1:0] pr_q, pr_d;
      logic [NS-1:0][TAG_W-1:0] pt_q, pt_d;

      // Shift the never-stalling pipeline by one stage every cycle
      always_comb begin
        pv_d[0] = issue;
        pn_d[0] = (Ufop == 3'b000);
        pr_d[0] = alu_res;
        pt_d[0] = Tag_in;
        for (int i = 1; i < NS; i++) begin
          pv_d[i] = pv_q[i-1];
          pn_d[i] = pn_q[i-1];
          pr_d[i] = pr_q[i-1];
          pt_d[i] = pt_q[i-1];
        end
      end

      // Pipeline registers; reset drops every in-flight op
      always_ff @(posedge Clock) begin
        if (Reset) begin
          pv_q <= '0;
          pn_q <= '0;
          pr_q <= '0;
          pt_q <= '0;
        end else begin
          pv_q <= pv_d;
          pn_q <= pn_d;
          pr_q <= pr_d;
          pt_q <= pt_d;
        end
      end

      always_comb begin
        exit_v   = pv_q[NS-1];
        exit_nop = pn_q[NS-1];
        exit_res = pr_q[NS-1];
        exit_tag = pt_q[NS-1];
      end
    end
  endgenerate

  assign buf_wr   = exit_v && !exit_nop;
  assign nop_exit = exit_v && exit_nop;

  logic [OUT_DEPTH-1:0][WIDTH-1:0] buf_res_q, buf_res_d;
  logic [OUT_DEPTH-1:0][TAG_W-1:0] buf_tag_q, buf_tag_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [CW-1:0]    credit_q, credit_d;
  logic [WIDTH-1:0] last_res_q, last_res_d;
  logic [TAG_W-1:0] last_tag_q, last_tag_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OUT_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign Write_Enable_CDB = (occ_q != '0);
  assign pop              = Write_Enable_CDB && CDB_grant;
  assign Busy             = (credit_q == CW'(OUT_DEPTH));
  // An empty buffer keeps showing the last result that left it
  assign Q     = Write_Enable_CDB ? buf_res_q[rd_ptr_q] : last_res_q;
  assign Q_tag = Write_Enable_CDB ? buf_tag_q[rd_ptr_q] : last_tag_q;

  // FIFO push/pop and credit accounting; push and pop together are legal at any occupancy
  always_comb begin
    buf_res_d  = buf_res_q;
    buf_tag_d  = buf_tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_res_d = last_res_q;
    last_tag_d = last_tag_q;
    if (buf_wr) begin
      buf_res_d[wr_ptr_q] = exit_res;
      buf_tag_d[wr_ptr_q] = exit_tag;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d   = ptr_inc(rd_ptr_q);
      last_res_d = buf_res_q[rd_ptr_q];
      last_tag_d = buf_tag_q[rd_ptr_q];
    end
    occ_d    = occ_q + CW'(buf_wr) - CW'(pop);
    credit_d = credit_q + CW'(issue) - CW'(pop) - CW'(nop_exit);
  end

  // Buffer and credit registers; reset empties everything
  always_ff @(posedge Clock) begin
    if (Reset) begin
      buf_res_q  <= '0;
      buf_tag_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      credit_q   <= '0;
      last_res_q <= '0;
      last_tag_q <= '0;
    end else begin
      buf_res_q  <= buf_res_d;
      buf_tag_q  <= buf_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      credit_q   <= credit_d;
      last_res_q <= last_res_d;
      last_tag_q <= last_tag_d;
    end
  end

endmodule

// File: tb/tb_unidade_funcional_r_pipe.sv
// Bench for unidade_funcional_r_pipe at default parameters (16-bit, tag 3,
// latency 2, depth 2). CDB writes are checked against an expected queue.
module tb_unidade_funcional_r_pipe;
  localparam int W  = 16;
  localparam int TW = 3;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [W-1:0]  A, B;
  logic [2:0]    Ufop;
  logic [TW-1:0] Tag_in;
  logic          Ready_to_uf;
  logic          Busy;
  logic [W-1:0]  Q;
  logic [TW-1:0] Q_tag;
  logic          Write_Enable_CDB;
  logic          CDB_grant;

  unidade_funcional_r_pipe dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .A                (A),
    .B                (B),
    .Ufop             (Ufop),
    .Tag_in           (Tag_in),
    .Ready_to_uf      (Ready_to_uf),
    .Busy             (Busy),
    .Q                (Q),
    .Q_tag            (Q_tag),
    .Write_Enable_CDB (Write_Enable_CDB),
    .CDB_grant        (CDB_grant)
  );

  // clock / watchdog
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [TW+W-1:0] exp_q[$];
  logic rnd_grant = 1'b0;

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] tag;
    logic [W-1:0]  exp;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd1: return a + b;
      3'd2: return (a < b) ? 16'd1 : 16'd0;
      3'd3: return (a == b) ? 16'd1 : 16'd0;
      3'd4: return b + 16'd4;
      3'd5: return b - 16'd4;
      3'd6: return a - b;
      3'd7: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  // scoreboard: every granted CDB write must match the oldest expected result
  always @(negedge Clock) begin
    if (!Reset && Write_Enable_CDB) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_cdb: got tag %0d q 0x%0h want no write", Q_tag, Q);
      end else if (CDB_grant) begin
        check("cdb_result", {13'd0, Q_tag, Q}, {13'd0, exp_q.pop_front()});
      end
    end
  end

  // random grant pattern when enabled
  always @(posedge Clock) begin
    if (rnd_grant) begin
      #1;
      CDB_grant = ($urandom_range(0, 3) != 0);
    end
  end

  // driver: wait (bounded) for Busy=0, then present the op for one edge
  task automatic do_issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input logic [W-1:0] res);
    int n = 0;
    while (Busy && n < 50) begin
      @(posedge Clock); #1;
      n++;
    end
    if (Busy) begin
      total++;
      bad++;
      $display("FAIL issue_wait: got busy 1 want 0");
    end else begin
      A = a; B = b; Ufop = op; Tag_in = tag; Ready_to_uf = 1'b1;
      if (op != 3'd0) exp_q.push_back({tag, res});
      @(posedge Clock); #1;
      Ready_to_uf = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    CDB_grant = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge Clock); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) begin @(posedge Clock); #1; end
    check("idle_busy", {31'd0, Busy}, 0);
  endtask

  initial begin
    Reset = 1'b1; A = '0; B = '0; Ufop = '0; Tag_in = '0;
    Ready_to_uf = 1'b0; CDB_grant = 1'b0;

    vecs[0]  = '{3'd1, 16'hFFFF, 16'h0001, 3'd0, 16'h0000};
    vecs[1]  = '{3'd1, 16'h1234, 16'h1111, 3'd1, 16'h2345};
    vecs[2]  = '{3'd2, 16'h0003, 16'h0005, 3'd2, 16'h0001};
    vecs[3]  = '{3'd2, 16'h0005, 16'h0003, 3'd3, 16'h0000};
    vecs[4]  = '{3'd2, 16'h0007, 16'h0007, 3'd4, 16'h0000};
    vecs[5]  = '{3'd3, 16'h0009, 16'h0009, 3'd5, 16'h0001};
    vecs[6]  = '{3'd3, 16'h0009, 16'h0008, 3'd6, 16'h0000};
    vecs[7]  = '{3'd4, 16'h0055, 16'hFFFE, 3'd7, 16'h0002};
    vecs[8]  = '{3'd5, 16'h0000, 16'h0002, 3'd0, 16'hFFFE};
    vecs[9]  = '{3'd6, 16'h0003, 16'h0005, 3'd1, 16'hFFFE};
    vecs[10] = '{3'd6, 16'h8000, 16'h0001, 3'd2, 16'h7FFF};
    vecs[11] = '{3'd7, 16'hFFFF, 16'h0001, 3'd4, 16'h0001};
    vecs[12] = '{3'd7, 16'h0001, 16'hFFFF, 3'd5, 16'h0000};
    vecs[13] = '{3'd7, 16'h8000, 16'h7FFF, 3'd6, 16'h0001};
    vecs[14] = '{3'd2, 16'hFFFF, 16'h0001, 3'd7, 16'h0000};

    // reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_busy", {31'd0, Busy}, 0);
    check("rst_we", {31'd0, Write_Enable_CDB}, 0);
    check("rst_q", {16'd0, Q}, 0);
    check("rst_tag", {29'd0, Q_tag}, 0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    // single ADD: result visible exactly 2 cycles after issue, for one cycle
    CDB_grant = 1'b1;
    do_issue(3'd1, 16'd5, 16'd7, 3'd3, 16'd12);
    check("lat_we_early", {31'd0, Write_Enable_CDB}, 0);
    check("lat_busy0", {31'd0, Busy}, 0);
    @(posedge Clock); #1;
    check("lat_we", {31'd0, Write_Enable_CDB}, 1);
    check("lat_q", {16'd0, Q}, 12);
    check("lat_tag", {29'd0, Q_tag}, 3);
    check("lat_busy1", {31'd0, Busy}, 0);
    @(posedge Clock); #1;
    check("lat_we_off", {31'd0, Write_Enable_CDB}, 0);
    wait_drain();

    // table of vectors, issued as fast as Busy allows
    for (int i = 0; i < 15; i++)
      do_issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);
    wait_drain();

    // backpressure: buffer fills, third request held off, then accepted after one pop
    CDB_grant = 1'b0;
    do_issue(3'd1, 16'd1, 16'd2, 3'd1, 16'd3);
    do_issue(3'd1, 16'd10, 16'd20, 3'd2, 16'd30);
    check("bp_busy_full", {31'd0, Busy}, 1);
    A = 16'd100; B = 16'd1; Ufop = 3'd1; Tag_in = 3'd5; Ready_to_uf = 1'b1;
    exp_q.push_back({3'd5, 16'd101});
    repeat (3) begin @(posedge Clock); #1; end
    check("bp_busy_hold", {31'd0, Busy}, 1);
    check("bp_head_hold", {13'd0, Q_tag, Q}, {13'd0, 3'd1, 16'd3});
    CDB_grant = 1'b1;
    @(posedge Clock); #1;
    CDB_grant = 1'b0;
    check("bp_busy_drop", {31'd0, Busy}, 0);
    check("bp_head_next", {13'd0, Q_tag, Q}, {13'd0, 3'd2, 16'd30});
    @(posedge Clock); #1;
    Ready_to_uf = 1'b0;
    check("bp_busy_again", {31'd0, Busy}, 1);
    wait_drain();

    // NOP gives no CDB write and returns its credit
    do_issue(3'd0, 16'd9, 16'd9, 3'd5, 16'd0);
    do_issue(3'd5, 16'd0, 16'd2, 3'd6, 16'hFFFE);
    wait_drain();
    CDB_grant = 1'b0;
    do_issue(3'd1, 16'd1, 16'd1, 3'd0, 16'd2);
    check("nop_credit", {31'd0, Busy}, 0);
    wait_drain();

    // pipeline exit and pop on the same edge
    CDB_grant = 1'b0;
    do_issue(3'd1, 16'd100, 16'd200, 3'd1, 16'd300);
    do_issue(3'd6, 16'd50, 16'd8, 3'd2, 16'd42);
    check("sim_we_pre", {31'd0, Write_Enable_CDB}, 1);
    CDB_grant = 1'b1;
    @(posedge Clock); #1;
    check("sim_head", {13'd0, Q_tag, Q}, {13'd0, 3'd2, 16'd42});
    check("sim_we_post", {31'd0, Write_Enable_CDB}, 1);
    check("sim_busy", {31'd0, Busy}, 0);
    wait_drain();

    // reset with work in flight and buffered: nothing reaches the CDB
    CDB_grant = 1'b0;
    do_issue(3'd1, 16'd1, 16'd2, 3'd3, 16'd3);
    do_issue(3'd1, 16'd4, 16'd5, 3'd4, 16'd9);
    Reset = 1'b1;
    exp_q.delete();
    @(posedge Clock); #1;
    Reset = 1'b0;
    check("mid_rst_we", {31'd0, Write_Enable_CDB}, 0);
    check("mid_rst_busy", {31'd0, Busy}, 0);
    check("mid_rst_q", {13'd0, Q_tag, Q}, 0);
    CDB_grant = 1'b1;
    repeat (6) begin
      @(posedge Clock); #1;
      check("post_rst_we", {31'd0, Write_Enable_CDB}, 0);
    end
    do_issue(3'd3, 16'd7, 16'd7, 3'd2, 16'd1);
    wait_drain();

    // random ops with random grant
    rnd_grant = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [2:0]    op;
      logic [W-1:0]  a, b;
      logic [TW-1:0] tg;
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      tg = 3'($urandom_range(0, 7));
      do_issue(op, a, b, tg, model(op, a, b));
    end
    rnd_grant = 1'b0;
    @(posedge Clock); #2;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
